branch_predictor: RTL and testbench

Parametrised dynamic branch predictor for the five-stage MIPS pipeline. It is looked up in IF with the current PC and predicts next-PC, so taken branches and jumps no longer cost three flushed stages on every execution. It is updated from MEM, where branches and jumps resolve. It flags mispredictions with the correct redirect PC and keeps saturating hit/miss statistics for the diagnostic monitor.

---
 rtl/branch_predictor_if.sv | 43 ++++
 rtl/branch_predictor.sv | 101 ++++++++++
 tb/tb_branch_predictor.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : branch_predictor_if                                             |
// | Brief   : Fetch-lookup / MEM-resolve / statistics bundle of the predictor. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface branch_predictor_if #(
    parameter int ADDR_W = 32,
    parameter int STAT_W = 16
);
    logic [ADDR_W-1:0] if_pc;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;

    logic              res_valid;
    logic              res_is_jump;
    logic [ADDR_W-1:0] res_pc;
    logic              res_taken;
    logic [ADDR_W-1:0] res_target;
    logic              res_pred_taken;
    logic [ADDR_W-1:0] res_pred_target;
    logic              mispredict;
    logic [ADDR_W-1:0] redirect_pc;

    logic [STAT_W-1:0] stat_branches;
    logic [STAT_W-1:0] stat_mispredicts;

    // Pipeline side: supplies fetch PC and resolved outcomes.
    modport master (
        output if_pc, res_valid, res_is_jump, res_pc, res_taken, res_target,
               res_pred_taken, res_pred_target,
        input  pred_taken, pred_target, mispredict, redirect_pc,
               stat_branches, stat_mispredicts
    );

    modport slave (
        input  if_pc, res_valid, res_is_jump, res_pc, res_taken, res_target,
               res_pred_taken, res_pred_target,
        output pred_taken, pred_target, mispredict, redirect_pc,
               stat_branches, stat_mispredicts
    );
endinterface
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : branch_predictor                                                 |
// | Brief   : Direct-mapped BTB with saturating direction counters and stats.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module branch_predictor #(
    parameter int ENTRIES = 16,   // power of two, >= 2
    parameter int CTR_W   = 2,    // 1..4
    parameter int ADDR_W  = 32,   // must match the interface instance
    parameter int STAT_W  = 16    // must match the interface instance
) (
    input  wire logic           clk,
    input  wire logic           rst,
    branch_predictor_if.slave   bp
);
    localparam int              c_IDX_W      = $clog2(ENTRIES);
    localparam int              c_TAG_W      = ADDR_W - c_IDX_W - 2;
    localparam logic [CTR_W-1:0]  c_CTR_ONE  = CTR_W'(1);
    localparam logic [CTR_W-1:0]  c_CTR_MAX  = '1;
    localparam logic [CTR_W-1:0]  c_CTR_WEAK = c_CTR_ONE << (CTR_W - 1);
    localparam logic [STAT_W-1:0] c_STAT_MAX = '1;
    localparam logic [STAT_W-1:0] c_STAT_ONE = STAT_W'(1);
    localparam logic [ADDR_W-1:0] c_PC_STEP  = ADDR_W'(4);

    logic                r_valid  [ENTRIES];
    logic [c_TAG_W-1:0]  r_tag    [ENTRIES];
    logic [ADDR_W-1:0]   r_target [ENTRIES];
    logic [CTR_W-1:0]    r_ctr    [ENTRIES];
    logic [STAT_W-1:0]   r_stat_branches;
    logic [STAT_W-1:0]   r_stat_mispredicts;

    logic [c_IDX_W-1:0]  w_if_idx;
    logic [c_TAG_W-1:0]  w_if_tag;
    logic                w_if_hit;
    logic                w_pred_taken;
    logic [c_IDX_W-1:0]  w_res_idx;
    logic [c_TAG_W-1:0]  w_res_tag;
    logic                w_res_hit;
    logic                w_mispredict;

    assign w_if_idx  = bp.if_pc[c_IDX_W+1:2];
    assign w_if_tag  = bp.if_pc[ADDR_W-1:c_IDX_W+2];
    assign w_res_idx = bp.res_pc[c_IDX_W+1:2];
    assign w_res_tag = bp.res_pc[ADDR_W-1:c_IDX_W+2];

    // Lookup reads the registered table only, so a same-cycle update is not visible.
    assign w_if_hit     = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign w_pred_taken = w_if_hit && r_ctr[w_if_idx][CTR_W-1];
    assign w_res_hit    = r_valid[w_res_idx] && (r_tag[w_res_idx] == w_res_tag);

    assign w_mispredict = bp.res_valid &&
                          ((bp.res_taken != bp.res_pred_taken) ||
                           (bp.res_taken && (bp.res_target != bp.res_pred_target)));

    assign bp.pred_taken       = w_pred_taken;
    assign bp.pred_target      = w_pred_taken ? r_target[w_if_idx] : bp.if_pc + c_PC_STEP;
    assign bp.mispredict       = w_mispredict;
    assign bp.redirect_pc      = bp.res_taken ? bp.res_target : bp.res_pc + c_PC_STEP;
    assign bp.stat_branches    = r_stat_branches;
    assign bp.stat_mispredicts = r_stat_mispredicts;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= '0;
            end
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else if (bp.res_valid) begin
            if (w_res_hit) begin
                if (bp.res_is_jump) begin
                    r_ctr[w_res_idx]    <= c_CTR_MAX;
                    r_target[w_res_idx] <= bp.res_target;
                end else if (bp.res_taken) begin
                    if (r_ctr[w_res_idx] != c_CTR_MAX) begin
                        r_ctr[w_res_idx] <= r_ctr[w_res_idx] + c_CTR_ONE;
                    end
                    r_target[w_res_idx] <= bp.res_target;
                end else if (r_ctr[w_res_idx] != '0) begin
                    r_ctr[w_res_idx] <= r_ctr[w_res_idx] - c_CTR_ONE;
                end
            end else if (bp.res_taken) begin
                // Allocation evicts whatever aliased entry held this slot.
                r_valid[w_res_idx]  <= 1'b1;
                r_tag[w_res_idx]    <= w_res_tag;
                r_target[w_res_idx] <= bp.res_target;
                r_ctr[w_res_idx]    <= bp.res_is_jump ? c_CTR_MAX : c_CTR_WEAK;
            end

            if (r_stat_branches != c_STAT_MAX) begin
                r_stat_branches <= r_stat_branches + c_STAT_ONE;
            end
            if (w_mispredict && (r_stat_mispredicts != c_STAT_MAX)) begin
                r_stat_mispredicts <= r_stat_mispredicts + c_STAT_ONE;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_branch_predictor                                              |
// | Brief   : Directed and random checks of branch_predictor against a model.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_branch_predictor;
    localparam int ENTRIES = 16;
    localparam int CTR_W   = 2;
    localparam int ADDR_W  = 32;
    localparam int STAT_W  = 4;
    localparam int CTR_MAX  = (1 << CTR_W) - 1;
    localparam int CTR_HALF = 1 << (CTR_W - 1);
    localparam int STAT_MAX = (1 << STAT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    branch_predictor_if #(.ADDR_W(ADDR_W), .STAT_W(STAT_W)) bp_if ();

    branch_predictor #(
        .ENTRIES(ENTRIES), .CTR_W(CTR_W), .ADDR_W(ADDR_W), .STAT_W(STAT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bp (bp_if)
    );

    always #5 clk = ~clk;

    // Reference model: one record per BTB slot, stats as plain integers.
    bit          m_valid [ENTRIES];
    logic [31:0] m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    int          m_br;
    int          m_mp;

    function automatic int m_slot(logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic bit m_hit(logic [31:0] pc);
        return m_valid[m_slot(pc)] && (m_tag[m_slot(pc)] == pc / (4 * ENTRIES));
    endfunction

    function automatic bit exp_taken(logic [31:0] pc);
        return m_hit(pc) && (m_ctr[m_slot(pc)] >= CTR_HALF);
    endfunction

    function automatic logic [31:0] exp_target(logic [31:0] pc);
        return exp_taken(pc) ? m_tgt[m_slot(pc)] : pc + 32'd4;
    endfunction

    function automatic bit exp_mispredict();
        return bp_if.res_valid &&
               ((bp_if.res_taken != bp_if.res_pred_taken) ||
                (bp_if.res_taken && (bp_if.res_target != bp_if.res_pred_target)));
    endfunction

    function automatic logic [31:0] exp_redirect();
        return bp_if.res_taken ? bp_if.res_target : bp_if.res_pc + 32'd4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 0;
        end
        m_br = 0;
        m_mp = 0;
    endtask

    task automatic model_update();
        int s;
        s = m_slot(bp_if.res_pc);
        if (exp_mispredict()) m_mp = (m_mp < STAT_MAX) ? m_mp + 1 : STAT_MAX;
        m_br = (m_br < STAT_MAX) ? m_br + 1 : STAT_MAX;
        if (m_hit(bp_if.res_pc)) begin
            if (bp_if.res_is_jump) begin
                m_ctr[s] = CTR_MAX;
                m_tgt[s] = bp_if.res_target;
            end else if (bp_if.res_taken) begin
                m_ctr[s] = (m_ctr[s] < CTR_MAX) ? m_ctr[s] + 1 : CTR_MAX;
                m_tgt[s] = bp_if.res_target;
            end else begin
                m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
            end
        end else if (bp_if.res_taken) begin
            m_valid[s] = 1'b1;
            m_tag[s]   = bp_if.res_pc / (4 * ENTRIES);
            m_tgt[s]   = bp_if.res_target;
            m_ctr[s]   = bp_if.res_is_jump ? CTR_MAX : CTR_HALF;
        end
    endtask

    // Advance one clock, mirroring the edge in the model, then settle 1 time unit.
    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else if (bp_if.res_valid) model_update();
        #1;
    endtask

    task automatic idle();
        bp_if.res_valid       = 1'b0;
        bp_if.res_is_jump     = 1'b0;
        bp_if.res_pc          = '0;
        bp_if.res_taken       = 1'b0;
        bp_if.res_target      = '0;
        bp_if.res_pred_taken  = 1'b0;
        bp_if.res_pred_target = '0;
    endtask

    task automatic resolve(input logic [31:0] pc, input bit jump, input bit taken,
                           input logic [31:0] tgt, input bit ptaken, input logic [31:0] ptgt);
        bp_if.res_valid       = 1'b1;
        bp_if.res_is_jump     = jump;
        bp_if.res_pc          = pc;
        bp_if.res_taken       = taken;
        bp_if.res_target      = tgt;
        bp_if.res_pred_taken  = ptaken;
        bp_if.res_pred_target = ptgt;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        bp_if.if_pc = '0;
        repeat (2) tick();
        rst = 1'b0;
        bp_if.if_pc = 32'h40;
        #1;
        checks++; if (bp_if.pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred_taken: got %0b expected 0", bp_if.pred_taken); end
        checks++; if (bp_if.pred_target !== 32'h44) begin errors++; $display("FAIL reset_pred_target: got %0h expected 44", bp_if.pred_target); end
        checks++; if (bp_if.mispredict !== 1'b0) begin errors++; $display("FAIL reset_mispredict: got %0b expected 0", bp_if.mispredict); end
        checks++; if (bp_if.stat_branches !== 4'd0) begin errors++; $display("FAIL reset_stat_br: got %0d expected 0", bp_if.stat_branches); end
        checks++; if (bp_if.stat_mispredicts !== 4'd0) begin errors++; $display("FAIL reset_stat_mp: got %0d expected 0", bp_if.stat_mispredicts); end
    endtask

    task automatic test_alloc();
        resolve(32'h40, 1'b0, 1'b1, 32'h80, 1'b0, 32'h44);
        #1;
        checks++; if (bp_if.mispredict !== 1'b1) begin errors++; $display("FAIL alloc_mispredict: got %0b expected 1", bp_if.mispredict); end
        checks++; if (bp_if.redirect_pc !== 32'h80) begin errors++; $display("FAIL alloc_redirect: got %0h expected 80", bp_if.redirect_pc); end
        tick();
        idle();
        bp_if.if_pc = 32'h40;
        #1;
        checks++; if (bp_if.pred_taken !== 1'b1) begin errors++; $display("FAIL alloc_pred_taken: got %0b expected 1", bp_if.pred_taken); end
        checks++; if (bp_if.pred_target !== 32'h80) begin errors++; $display("FAIL alloc_pred_target: got %0h expected 80", bp_if.pred_target); end
        checks++; if (bp_if.stat_branches !== 4'd1) begin errors++; $display("FAIL alloc_stat_br: got %0d expected 1", bp_if.stat_branches); end
        checks++; if (bp_if.stat_mispredicts !== 4'd1) begin errors++; $display("FAIL alloc_stat_mp: got %0d expected 1", bp_if.stat_mispredicts); end
    endtask

    task automatic test_counter();
        bit exp_seq [4];
        exp_seq = '{1'b0, 1'b1, 1'b1, 1'b1};
        resolve(32'h40, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80);
        #1;
        checks++; if (bp_if.mispredict !== 1'b1) begin errors++; $display("FAIL ctr_nt_mispredict: got %0b expected 1", bp_if.mispredict); end
        checks++; if (bp_if.redirect_pc !== 32'h44) begin errors++; $display("FAIL ctr_nt_redirect: got %0h expected 44", bp_if.redirect_pc); end
        tick();
        idle();
        bp_if.if_pc = 32'h40;
        #1;
        checks++; if (bp_if.pred_taken !== 1'b0) begin errors++; $display("FAIL ctr_weak_nt_pred: got %0b expected 0", bp_if.pred_taken); end
        resolve(32'h40, 1'b0, 1'b0, 32'h80, 1'b0, 32'h44);
        #1;
        checks++; if (bp_if.mispredict !== 1'b0) begin errors++; $display("FAIL ctr_nt2_mispredict: got %0b expected 0", bp_if.mispredict); end
        tick();
        for (int k = 0; k < 4; k++) begin
            resolve(32'h40, 1'b0, 1'b1, 32'h80, exp_taken(32'h40), exp_target(32'h40));
            tick();
            idle();
            #1;
            checks++; if (bp_if.pred_taken !== exp_seq[k]) begin errors++; $display("FAIL ctr_up_%0d: got %0b expected %0b", k, bp_if.pred_taken, exp_seq[k]); end
        end
        // After saturating at max, a single not-taken must leave it predicting taken.
        resolve(32'h40, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80);
        tick();
        idle();
        #1;
        checks++; if (bp_if.pred_taken !== 1'b1) begin errors++; $display("FAIL ctr_saturate: got %0b expected 1", bp_if.pred_taken); end
        checks++; if (bp_if.pred_target !== 32'h80) begin errors++; $display("FAIL ctr_sat_target: got %0h expected 80", bp_if.pred_target); end
    endtask

    task automatic test_alias();
        do_reset();
        resolve(32'h40, 1'b0, 1'b1, 32'h100, 1'b0, 32'h44);
        tick();
        resolve(32'h80, 1'b0, 1'b1, 32'h200, 1'b0, 32'h84);
        tick();
        idle();
        bp_if.if_pc = 32'h40;
        #1;
        checks++; if (bp_if.pred_taken !== 1'b0) begin errors++; $display("FAIL alias_old_pred: got %0b expected 0", bp_if.pred_taken); end
        checks++; if (bp_if.pred_target !== 32'h44) begin errors++; $display("FAIL alias_old_target: got %0h expected 44", bp_if.pred_target); end
        bp_if.if_pc = 32'h83;
        #1;
        checks++; if (bp_if.pred_taken !== 1'b1) begin errors++; $display("FAIL alias_new_pred: got %0b expected 1", bp_if.pred_taken); end
        checks++; if (bp_if.pred_target !== 32'h200) begin errors++; $display("FAIL alias_new_target: got %0h expected 200", bp_if.pred_target); end
    endtask

    task automatic test_jump();
        resolve(32'h10, 1'b1, 1'b1, 32'h400, 1'b0, 32'h14);
        tick();
        resolve(32'h10, 1'b0, 1'b0, 32'h400, 1'b1, 32'h400);
        tick();
        idle();
        bp_if.if_pc = 32'h10;
        #1;
        checks++; if (bp_if.pred_taken !== 1'b1) begin errors++; $display("FAIL jump_strong_pred: got %0b expected 1", bp_if.pred_taken); end
        checks++; if (bp_if.pred_target !== 32'h400) begin errors++; $display("FAIL jump_target: got %0h expected 400", bp_if.pred_target); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        resolve(32'h40, 1'b0, 1'b1, 32'h80, 1'b0, 32'h44);
        bp_if.if_pc = 32'h40;
        #1;
        checks++; if (bp_if.pred_taken !== 1'b0) begin errors++; $display("FAIL same_cycle_old: got %0b expected 0", bp_if.pred_taken); end
        checks++; if (bp_if.pred_target !== 32'h44) begin errors++; $display("FAIL same_cycle_old_tgt: got %0h expected 44", bp_if.pred_target); end
        tick();
        idle();
        #1;
        checks++; if (bp_if.pred_taken !== 1'b1) begin errors++; $display("FAIL same_cycle_new: got %0b expected 1", bp_if.pred_taken); end
    endtask

    task automatic test_reset_with_update();
        rst = 1'b1;
        resolve(32'hC0, 1'b0, 1'b1, 32'h300, 1'b0, 32'hC4);
        tick();
        rst = 1'b0;
        idle();
        bp_if.if_pc = 32'h40;
        #1;
        checks++; if (bp_if.pred_taken !== 1'b0) begin errors++; $display("FAIL rstupd_history: got %0b expected 0", bp_if.pred_taken); end
        bp_if.if_pc = 32'hC0;
        #1;
        checks++; if (bp_if.pred_taken !== 1'b0) begin errors++; $display("FAIL rstupd_no_write: got %0b expected 0", bp_if.pred_taken); end
        checks++; if (bp_if.stat_branches !== 4'd0) begin errors++; $display("FAIL rstupd_stat_br: got %0d expected 0", bp_if.stat_branches); end
        checks++; if (bp_if.stat_mispredicts !== 4'd0) begin errors++; $display("FAIL rstupd_stat_mp: got %0d expected 0", bp_if.stat_mispredicts); end
    endtask

    task automatic test_random();
        logic [31:0] pc, rpc, tgt;
        bit          jump, taken;
        for (int n = 0; n < 400; n++) begin
            pc  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            rpc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            tgt = $urandom_range(0, 255) << 2;
            jump  = ($urandom_range(0, 4) == 0);
            taken = jump ? 1'b1 : 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) != 0) resolve(rpc, jump, taken, tgt, exp_taken(rpc), exp_target(rpc));
            else resolve(rpc, jump, taken, tgt, 1'($urandom_range(0, 1)), $urandom_range(0, 255) << 2);
            if ($urandom_range(0, 3) == 0) bp_if.res_valid = 1'b0;
            bp_if.if_pc = pc;
            #1;
            checks++; if (bp_if.pred_taken !== exp_taken(pc)) begin errors++; $display("FAIL rand_pred_taken[%0d]: got %0b expected %0b", n, bp_if.pred_taken, exp_taken(pc)); end
            checks++; if (bp_if.pred_target !== exp_target(pc)) begin errors++; $display("FAIL rand_pred_target[%0d]: got %0h expected %0h", n, bp_if.pred_target, exp_target(pc)); end
            checks++; if (bp_if.mispredict !== exp_mispredict()) begin errors++; $display("FAIL rand_mispredict[%0d]: got %0b expected %0b", n, bp_if.mispredict, exp_mispredict()); end
            checks++; if (bp_if.redirect_pc !== exp_redirect()) begin errors++; $display("FAIL rand_redirect[%0d]: got %0h expected %0h", n, bp_if.redirect_pc, exp_redirect()); end
            tick();
        end
        idle();
        #1;
        checks++; if (int'(bp_if.stat_branches) != m_br) begin errors++; $display("FAIL rand_stat_br: got %0d expected %0d", bp_if.stat_branches, m_br); end
        checks++; if (int'(bp_if.stat_mispredicts) != m_mp) begin errors++; $display("FAIL rand_stat_mp: got %0d expected %0d", bp_if.stat_mispredicts, m_mp); end
    endtask

    task automatic test_stat_saturation();
        logic [31:0] pc;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            pc = 32'h1000 + 32'(i) * 4;
            resolve(pc, 1'b0, 1'b1, 32'h2000 + 32'(i) * 4, 1'b0, pc + 32'd4);
            tick();
        end
        idle();
        #1;
        checks++; if (bp_if.stat_branches !== 4'd15) begin errors++; $display("FAIL sat_stat_br: got %0d expected 15", bp_if.stat_branches); end
        checks++; if (bp_if.stat_mispredicts !== 4'd15) begin errors++; $display("FAIL sat_stat_mp: got %0d expected 15", bp_if.stat_mispredicts); end
    endtask

    initial begin
        idle();
        bp_if.if_pc = '0;
        model_reset();
        test_reset();
        test_alloc();
        test_counter();
        test_alias();
        test_jump();
        test_same_cycle();
        test_reset_with_update();
        test_random();
        test_stat_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
